coeffs_load_sequencer: RTL

//  Streams a full coefficient set from the host interface into the coefficient register bank (write_address/coeffs_in/write_enable).

---
 rtl/coeffs_load_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/coeffs_load_sequencer.sv
// Streams one coefficient set into the bank, then commits it on a current_count boundary.
// Optional trailing checksum word and accumulator: define COEFF_LOAD_CHECKSUM_EN.
module coeffs_load_sequencer #(
   parameter int NUM_COEFFS = 64,
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 6,
   parameter int SYNC_COUNT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_enable,
   input  logic              load_start,
   input  logic              load_abort,
   input  logic              coeff_valid,
   input  logic [DATA_W-1:0] coeff_data,
   output logic              coeff_ready,
   input  logic [ADDR_W-1:0] current_count,
   output logic [ADDR_W-1:0] write_address,
   output logic [DATA_W-1:0] coeffs_in,
   output logic              write_enable,
   output logic              coeffs_en,
   output logic              busy,
   output logic              load_done,
   output logic              load_error
);

`ifdef COEFF_LOAD_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, LOAD, CHECK, WAIT_SYNC} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, WAIT_SYNC} state_t;
`endif

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_COEFFS - 1);
   localparam logic [ADDR_W-1:0] SYNC_VAL = ADDR_W'(SYNC_COUNT);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] index_q, index_d;
   logic              coeffs_en_q, coeffs_en_d;
   logic              load_done_q, load_done_d;
   logic              load_error_q, load_error_d;
   logic              busy_q, busy_d;
`ifdef COEFF_LOAD_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
`endif

   always_comb begin
      state_d      = state_q;
      index_d      = index_q;
      coeffs_en_d  = 1'b0;
      load_done_d  = 1'b0;
      load_error_d = 1'b0;
      coeff_ready  = 1'b0;
      write_enable = 1'b0;
`ifdef COEFF_LOAD_CHECKSUM_EN
      sum_d        = sum_q;
`endif
      case (state_q)
         IDLE: begin
            if (load_start) begin
               state_d = LOAD;
               index_d = '0;
`ifdef COEFF_LOAD_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         LOAD: begin
            coeff_ready = clk_enable;
            if (coeff_valid && clk_enable) begin
               write_enable = 1'b1;
`ifdef COEFF_LOAD_CHECKSUM_EN
               sum_d        = sum_q + coeff_data;
`endif
               if (index_q == LAST_IDX) begin
                  index_d = '0;
`ifdef COEFF_LOAD_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = WAIT_SYNC;
`endif
               end else begin
                  index_d = index_q + 1'b1;
               end
            end
         end
`ifdef COEFF_LOAD_CHECKSUM_EN
         CHECK: begin
            // The checksum word is consumed here but never written to the bank.
            coeff_ready = clk_enable;
            if (coeff_valid && clk_enable) begin
               if (sum_q == coeff_data) begin
                  state_d = WAIT_SYNC;
               end else begin
                  state_d      = IDLE;
                  load_error_d = 1'b1;
               end
            end
         end
`endif
         WAIT_SYNC: begin
            if (clk_enable && (current_count == SYNC_VAL)) begin
               coeffs_en_d = 1'b1;
               load_done_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Abort beats restart; either one cancels any pending commit.
      if (state_q != IDLE) begin
         if (load_abort) begin
            state_d      = IDLE;
            index_d      = '0;
            load_error_d = 1'b1;
            coeffs_en_d  = 1'b0;
            load_done_d  = 1'b0;
         end else if (load_start) begin
            state_d      = LOAD;
            index_d      = '0;
            load_error_d = 1'b1;
            coeffs_en_d  = 1'b0;
            load_done_d  = 1'b0;
`ifdef COEFF_LOAD_CHECKSUM_EN
            sum_d        = '0;
`endif
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         index_q      <= '0;
         coeffs_en_q  <= 1'b0;
         load_done_q  <= 1'b0;
         load_error_q <= 1'b0;
         busy_q       <= 1'b0;
`ifdef COEFF_LOAD_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         index_q      <= index_d;
         coeffs_en_q  <= coeffs_en_d;
         load_done_q  <= load_done_d;
         load_error_q <= load_error_d;
         busy_q       <= busy_d;
`ifdef COEFF_LOAD_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   assign write_address = index_q;
   assign coeffs_in     = coeff_data;
   assign coeffs_en     = coeffs_en_q;
   assign load_done     = load_done_q;
   assign load_error    = load_error_q;
   assign busy          = busy_q;

endmodule
